// File: rtl/mem_dma.sv
// Word-copy DMA engine: slave register port on the core bus,
// initiator port copying LEN words from SRC to DST.
module mem_dma #(
  parameter int LEN_W    = 16,
  parameter int BASE_OFS = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_di,
  output logic [31:0] dma_do,
  output logic        dma_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      wdata_q;
  logic [LEN_W-1:0] len_q;
  logic             done_q;
  logic             ien_q;

  logic        busy;
  logic        acc;
  logic        wr_en;
  logic        sel_src;
  logic        sel_dst;
  logic        sel_len;
  logic        sel_ctrl;
  logic        start_go;
  logic        w1c;
  logic        rd_done;
  logic        wr_done;
  logic        last_word;
  logic [31:0] rd_data;

  logic unused_ok;
  assign unused_ok = ^{32'(BASE_OFS), addr[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = din[8*i +: 8];
    end
    return r;
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign last_word = (len_q == LEN_W'(1));
  assign m_wdata   = wdata_q;
  assign irq       = done_q & ien_q;

  // Slave access decode; an access is the first cycle of sel.
  always_comb begin
    acc      = dma_sel & ~dma_ready;
    wr_en    = acc & (|dma_wstrb);
    sel_src  = 1'b0;
    sel_dst  = 1'b0;
    sel_len  = 1'b0;
    sel_ctrl = 1'b0;
    unique case (1'b1)
      (addr[3:2] == 2'd0): sel_src  = wr_en;
      (addr[3:2] == 2'd1): sel_dst  = wr_en;
      (addr[3:2] == 2'd2): sel_len  = wr_en;
      (addr[3:2] == 2'd3): sel_ctrl = wr_en;
      default: ;
    endcase
    start_go = sel_ctrl & dma_wstrb[0] & dma_di[0] & ~busy;
    w1c      = sel_ctrl & dma_wstrb[0] & dma_di[1];
    rd_data  = '0;
    unique case (1'b1)
      (addr[3:2] == 2'd0): rd_data = src_q;
      (addr[3:2] == 2'd1): rd_data = dst_q;
      (addr[3:2] == 2'd2): rd_data = 32'(len_q);
      (addr[3:2] == 2'd3): rd_data = {29'b0, ien_q, done_q, busy};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Each bus phase is followed by a gap state so m_valid
  // always returns low between transactions.
  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wstrb = '0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_go && len_q != '0) state_d = S_RD;
      end
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = src_q;
        if (m_ready) begin
          rd_done = 1'b1;
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: state_d = S_WR;
      S_WR: begin
        m_valid = 1'b1;
        m_addr  = dst_q;
        m_wstrb = 4'hF;
        if (m_ready) begin
          wr_done = 1'b1;
          state_d = last_word ? S_IDLE : S_WR_GAP;
        end
      end
      S_WR_GAP: state_d = S_RD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ien_q     <= 1'b0;
      dma_ready <= 1'b0;
      dma_do    <= '0;
    end else begin
      dma_ready <= acc;
      dma_do    <= acc ? rd_data : '0;

      if (sel_src && !busy)
        src_q <= merge(src_q, dma_di, dma_wstrb) & ~32'h3;
      else if (wr_done)
        src_q <= src_q + 32'd4;

      if (sel_dst && !busy)
        dst_q <= merge(dst_q, dma_di, dma_wstrb) & ~32'h3;
      else if (wr_done)
        dst_q <= dst_q + 32'd4;

      if (sel_len && !busy)
        len_q <= LEN_W'(merge(32'(len_q), dma_di, dma_wstrb));
      else if (wr_done)
        len_q <= len_q - LEN_W'(1);

      if (sel_ctrl && dma_wstrb[0])
        ien_q <= dma_di[2];

      // Completion beats a same-cycle clear; START beats its own clear.
      if (wr_done && last_word)
        done_q <= 1'b1;
      else if (start_go)
        done_q <= (len_q == '0);
      else if (w1c)
        done_q <= 1'b0;

      if (rd_done)
        wdata_q <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Randomized bench for mem_dma: memory responder with random
// latency, copy reference model and register checks.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_sel;
  logic [3:0]  addr;
  logic [3:0]  dma_wstrb;
  logic [31:0] dma_di;
  logic [31:0] dma_do;
  logic        dma_ready;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        irq;

  localparam logic [1:0] R_SRC  = 2'd0;
  localparam logic [1:0] R_DST  = 2'd1;
  localparam logic [1:0] R_LEN  = 2'd2;
  localparam logic [1:0] R_CTRL = 2'd3;

  int vectors   = 0;
  int errors    = 0;
  int nvalid    = 0;
  int max_delay = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_a [$];
  bit          log_w [$];
  logic [31:0] exp_q [$];

  mem_dma dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dma_sel   (dma_sel),
    .addr      (addr),
    .dma_wstrb (dma_wstrb),
    .dma_di    (dma_di),
    .dma_do    (dma_do),
    .dma_ready (dma_ready),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Memory responder: random latency, checks request hold.
  initial begin : mem_model
    int          lat;
    bit          act;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [3:0]  cs;
    lat = 0; act = 0; ca = 0; cd = 0; cs = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (m_ready) begin
        m_ready = 1'b0;
        m_rdata = '0;
        act = 0;
      end else if (!m_valid) begin
        act = 0;
      end else begin
        if (!act) begin
          act = 1;
          lat = int'($urandom_range(max_delay, 0));
          ca = m_addr; cd = m_wdata; cs = m_wstrb;
          nvalid++;
        end else begin
          chk("hold_addr", m_addr, ca);
          chk("hold_wstrb", 32'(m_wstrb), 32'(cs));
          if (cs == 4'hF) chk("hold_wdata", m_wdata, cd);
        end
        if (lat == 0) begin
          if (cs == 4'hF) mem[ca] = cd;
          else m_rdata = rd_word(ca);
          log_a.push_back(ca);
          log_w.push_back(cs == 4'hF);
          m_ready = 1'b1;
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic bus(input logic [1:0] r, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    dma_sel = 1'b1; addr = {r, 2'b00}; dma_wstrb = s; dma_di = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!dma_ready && n < 4);
    chk("slave_ready", 32'(dma_ready), 32'd1);
    q = dma_do;
    dma_sel = 1'b0; dma_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    bus(r, d, 4'hF, q);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] q);
    bus(r, 32'h0, 4'h0, q);
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    int n;
    n = 0;
    do begin
      rd(R_CTRL, q);
      n++;
    end while (q[0] && n < 2000);
    chk("busy_timeout", 32'(q[0]), 32'd0);
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic [31:0] ctrl);
    exp_q.delete();
    log_a.delete();
    log_w.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      a = src + 32'(4 * i);
      mem[a] = $urandom;
      exp_q.push_back(mem[a]);
    end
    wr(R_SRC, src);
    wr(R_DST, dst);
    wr(R_LEN, 32'(len));
    wr(R_CTRL, ctrl);
  endtask

  task automatic verify_copy(input logic [31:0] src, input logic [31:0] dst,
                             input int len, input logic ien);
    logic [31:0] q;
    rd(R_SRC, q);  chk("src_end", q, src + 32'(4 * len));
    rd(R_DST, q);  chk("dst_end", q, dst + 32'(4 * len));
    rd(R_LEN, q);  chk("len_end", q, 32'h0);
    rd(R_CTRL, q); chk("ctrl_end", q, {29'b0, ien, 2'b10});
    chk("irq_end", 32'(irq), 32'(ien));
    chk("n_xfers", 32'(log_a.size()), 32'(2 * len));
    if (log_a.size() == 2 * len) begin
      for (int i = 0; i < len; i++) begin
        chk("rd_addr", log_a[2*i], src + 32'(4 * i));
        chk("rd_kind", 32'(log_w[2*i]), 32'd0);
        chk("wr_addr", log_a[2*i+1], dst + 32'(4 * i));
        chk("wr_kind", 32'(log_w[2*i+1]), 32'd1);
      end
    end
    for (int i = 0; i < len; i++)
      chk("dst_data", rd_word(dst + 32'(4 * i)), exp_q[i]);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] q;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          n0;
    int          n;

    reset_n = 1'b0; dma_sel = 1'b0; addr = '0;
    dma_wstrb = '0; dma_di = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    chk("rst_dma_ready", 32'(dma_ready), 32'd0);
    chk("rst_dma_do", dma_do, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    rd(R_SRC, q);  chk("rst_src", q, 32'h0);
    rd(R_DST, q);  chk("rst_dst", q, 32'h0);
    rd(R_LEN, q);  chk("rst_len", q, 32'h0);
    rd(R_CTRL, q); chk("rst_ctrl", q, 32'h0);

    // register write semantics
    wr(R_SRC, 32'h0000_0103);
    rd(R_SRC, q); chk("src_align", q, 32'h0000_0100);
    wr(R_LEN, 32'hFFFF_FFFF);
    rd(R_LEN, q); chk("len_width", q, 32'h0000_FFFF);
    wr(R_LEN, 32'h0000_1234);
    bus(R_LEN, 32'h0000_AB00, 4'b0010, q);
    rd(R_LEN, q); chk("len_byte", q, 32'h0000_AB34);

    // basic 4-word copy, fastest memory
    max_delay = 0;
    start_copy(32'h100, 32'h200, 4, 32'h1);
    wait_idle();
    verify_copy(32'h100, 32'h200, 4, 1'b0);

    // LEN=0 start, irq and W1C
    wr(R_CTRL, 32'h2);
    rd(R_CTRL, q); chk("w1c_clear", q, 32'h0);
    n0 = nvalid;
    wr(R_LEN, 32'h0);
    wr(R_CTRL, 32'h5);
    chk("len0_irq", 32'(irq), 32'd1);
    repeat (5) @(posedge clk);
    rd(R_CTRL, q); chk("len0_ctrl", q, 32'h6);
    chk("len0_no_xfer", 32'(nvalid - n0), 32'd0);
    wr(R_CTRL, 32'h2);
    chk("w1c_irq", 32'(irq), 32'd0);
    rd(R_CTRL, q); chk("w1c_ctrl", q, 32'h0);

    // random copies with random memory latency
    max_delay = 5;
    for (int k = 0; k < 6; k++) begin
      src = $urandom & 32'h7FFF_FFFC;
      dst = src ^ 32'h8000_0000;
      len = int'($urandom_range(6, 1));
      start_copy(src, dst, len, {29'b0, k[0], 2'b01});
      wait_idle();
      verify_copy(src, dst, len, k[0]);
    end

    // writes and START while busy are ignored
    max_delay = 2;
    start_copy(32'h1000, 32'h2000, 8, 32'h1);
    wr(R_SRC, 32'h0000_DEAD);
    wr(R_CTRL, 32'h1);
    rd(R_CTRL, q); chk("busy_bit", q & 32'h1, 32'h1);
    wait_idle();
    verify_copy(32'h1000, 32'h2000, 8, 1'b0);

    // address wrap
    max_delay = 0;
    start_copy(32'hFFFF_FFFC, 32'h300, 2, 32'h1);
    wait_idle();
    verify_copy(32'hFFFF_FFFC, 32'h300, 2, 1'b0);
    if (log_a.size() >= 3) chk("wrap_rd_addr", log_a[2], 32'h0);

    // reset during a write phase
    max_delay = 3;
    start_copy(32'h400, 32'h500, 4, 32'h5);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(m_valid && m_wstrb == 4'hF) && n < 200);
    chk("reach_wr", 32'(m_valid && m_wstrb == 4'hF), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    rd(R_CTRL, q); chk("mid_rst_ctrl", q, 32'h0);
    rd(R_LEN, q);  chk("mid_rst_len", q, 32'h0);
    rd(R_SRC, q);  chk("mid_rst_src", q, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
